// File: rtl/dec_rec_pkg.sv
// rtl/dec_rec_pkg.sv - shared constants, block-entry type and clip helper for the reconstruction output stage
package dec_rec_pkg;
    localparam int BPC  = 8;
    localparam int NPIX = 16;
    localparam int IW   = BPC + 3;
    localparam int IDXW = $clog2(NPIX);
    localparam logic [BPC-1:0] MID = BPC'(1 << (BPC - 1));

    typedef logic [NPIX-1:0][BPC-1:0] c0_blk_t;
    typedef logic [NPIX-1:0][BPC:0]   cx_blk_t;

    typedef struct packed {
        c0_blk_t c0;
        cx_blk_t c1;
        cx_blk_t c2;
        logic    ycocg;
    } blk_t;

    // Saturate a signed intermediate into the unsigned BPC-bit pixel range.
    function automatic logic [BPC-1:0] clip(input logic signed [IW-1:0] v);
        if (v[IW-1])
            return '0;
        else if (|v[IW-2:BPC])
            return '1;
        else
            return v[BPC-1:0];
    endfunction
endpackage

// File: rtl/dec_rec_out_if.sv
// rtl/dec_rec_out_if.sv - block input stream and pixel output stream of dec_rec_out
interface dec_rec_out_if;
    import dec_rec_pkg::*;

    logic           rec_vld;
    logic           rec_rdy;
    logic           is_ycocg;
    c0_blk_t        pRec0;
    cx_blk_t        pRec1;
    cx_blk_t        pRec2;

    logic           pix_vld;
    logic           pix_rdy;
    logic [BPC-1:0] pix_r;
    logic [BPC-1:0] pix_g;
    logic [BPC-1:0] pix_b;
    logic           pix_sob;
    logic           pix_eob;

    modport master (
        output rec_vld, is_ycocg, pRec0, pRec1, pRec2, pix_rdy,
        input  rec_rdy, pix_vld, pix_r, pix_g, pix_b, pix_sob, pix_eob
    );

    modport slave (
        input  rec_vld, is_ycocg, pRec0, pRec1, pRec2, pix_rdy,
        output rec_rdy, pix_vld, pix_r, pix_g, pix_b, pix_sob, pix_eob
    );
endinterface

// File: rtl/dec_ycocg2rgb.sv
// rtl/dec_ycocg2rgb.sv - single-pixel inverse YCoCg-R (or RGB pass-through) with clipping
module dec_ycocg2rgb
    import dec_rec_pkg::*;
(
    input  logic           ycocg,
    input  logic [BPC-1:0] c0,
    input  logic [BPC:0]   c1,
    input  logic [BPC:0]   c2,
    output logic [BPC-1:0] r,
    output logic [BPC-1:0] g,
    output logic [BPC-1:0] b
);
    logic signed [IW-1:0] y_s;
    logic signed [IW-1:0] co_s;
    logic signed [IW-1:0] cg_s;
    logic signed [IW-1:0] t_s;
    logic signed [IW-1:0] r_s;
    logic signed [IW-1:0] g_s;
    logic signed [IW-1:0] b_s;

    always_comb begin
        y_s = $signed({{(IW-BPC){1'b0}}, c0});
        if (ycocg) begin
            co_s = $signed({{(IW-BPC-1){c1[BPC]}}, c1});
            cg_s = $signed({{(IW-BPC-1){c2[BPC]}}, c2});
            t_s  = y_s - (cg_s >>> 1);
            g_s  = cg_s + t_s;
            b_s  = t_s - (co_s >>> 1);
            r_s  = b_s + co_s;
        end else begin
            // RGB mode: c1/c2 are unsigned and only need saturating.
            co_s = $signed({{(IW-BPC-1){1'b0}}, c1});
            cg_s = $signed({{(IW-BPC-1){1'b0}}, c2});
            t_s  = '0;
            r_s  = y_s;
            g_s  = co_s;
            b_s  = cg_s;
        end
        r = clip(r_s);
        g = clip(g_s);
        b = clip(b_s);
    end
endmodule

// File: rtl/dec_rec_out.sv
// rtl/dec_rec_out.sv - two-entry block store, prev_rec feedback and one-pixel-per-cycle colour output
module dec_rec_out
    import dec_rec_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         slice_start,
    dec_rec_out_if.slave bus,
    output c0_blk_t      prev_rec_c0,
    output cx_blk_t      prev_rec_c1,
    output cx_blk_t      prev_rec_c2,
    output logic         ovf_err
);
    blk_t            mem [2];
    blk_t            rd_blk;
    logic [1:0]      cnt;
    logic            wr_ptr;
    logic            rd_ptr;
    logic [IDXW-1:0] pix_idx;
    logic            accept;
    logic            load;
    logic            last_pix;
    logic            release_blk;
    logic [BPC-1:0]  r;
    logic [BPC-1:0]  g;
    logic [BPC-1:0]  b;

    // Ready looks only at the registered count so it never depends on pix_rdy.
    assign bus.rec_rdy = (cnt < 2'd2);
    assign accept      = bus.rec_vld & bus.rec_rdy;
    assign load        = (cnt != 2'd0) & (~bus.pix_vld | bus.pix_rdy);
    assign last_pix    = (pix_idx == IDXW'(NPIX - 1));
    assign release_blk = load & last_pix;
    assign rd_blk      = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (accept)
            mem[wr_ptr] <= {bus.pRec0, bus.pRec1, bus.pRec2, bus.is_ycocg};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= 2'd0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            pix_idx <= '0;
            ovf_err <= 1'b0;
        end else begin
            cnt <= cnt + 2'(accept) - 2'(release_blk);
            if (accept)
                wr_ptr <= ~wr_ptr;
            if (bus.rec_vld && !bus.rec_rdy)
                ovf_err <= 1'b1;
            if (load) begin
                pix_idx <= last_pix ? '0 : pix_idx + IDXW'(1);
                if (last_pix)
                    rd_ptr <= ~rd_ptr;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_rec_c0 <= {NPIX{MID}};
            prev_rec_c1 <= '0;
            prev_rec_c2 <= '0;
        end else if (accept) begin
            prev_rec_c0 <= bus.pRec0;
            prev_rec_c1 <= bus.pRec1;
            prev_rec_c2 <= bus.pRec2;
        end else if (slice_start) begin
            prev_rec_c0 <= {NPIX{MID}};
            prev_rec_c1 <= '0;
            prev_rec_c2 <= '0;
        end
    end

    dec_ycocg2rgb u_cvt (
        .ycocg (rd_blk.ycocg),
        .c0    (rd_blk.c0[pix_idx]),
        .c1    (rd_blk.c1[pix_idx]),
        .c2    (rd_blk.c2[pix_idx]),
        .r     (r),
        .g     (g),
        .b     (b)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.pix_vld <= 1'b0;
            bus.pix_r   <= '0;
            bus.pix_g   <= '0;
            bus.pix_b   <= '0;
            bus.pix_sob <= 1'b0;
            bus.pix_eob <= 1'b0;
        end else if (load) begin
            bus.pix_vld <= 1'b1;
            bus.pix_r   <= r;
            bus.pix_g   <= g;
            bus.pix_b   <= b;
            bus.pix_sob <= (pix_idx == '0);
            bus.pix_eob <= last_pix;
        end else if (bus.pix_rdy) begin
            bus.pix_vld <= 1'b0;
        end
    end
endmodule
